ifetch_bridge: RTL and testbench

- Sits directly upstream of the core's instruction port: consumes the core's fetch request (inst_addr, inst_ena) and returns the 32-bit instruction word the core decodes.
- Bridges to a 64-bit instruction memory with a valid/ready request channel and a variable-latency response channel.
- Holds a one-entry 8-byte line buffer, so both halves of a doubleword hit without a memory access.
- Asserts a stall while a miss is outstanding; the core holds its PC while stall is high.

---
 rtl/ifetch_bridge.sv | 92 +++++++++
 tb/tb_ifetch_bridge.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_bridge.sv
// ifetch_bridge: 32-bit core fetch port bridged to a 64-bit valid/ready instruction memory
// through a one-entry doubleword line buffer; stalls the core while a miss is outstanding.
module ifetch_bridge #(
    parameter int          ADDR_W   = 64,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] inst_addr,
    input  logic              inst_ena,
    input  logic              flush,
    output logic [31:0]       inst,
    output logic              inst_valid,
    output logic              stall,
    output logic              inst_misaligned,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_resp_valid,
    input  logic [63:0]       mem_resp_data
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t            state;
    logic              buf_valid;
    logic [ADDR_W-4:0] buf_tag;
    logic [ADDR_W-4:0] req_tag;
    logic [63:0]       buf_data;
    logic              drop;
    logic              hit;
    logic              miss;

    assign inst_misaligned = inst_ena & (inst_addr[1:0] != 2'b00);
    assign hit             = inst_ena & ~inst_misaligned & buf_valid
                           & (buf_tag == inst_addr[ADDR_W-1:3]) & (state == IDLE);
    assign miss            = inst_ena & ~inst_misaligned & ~hit;
    assign inst_valid      = hit;
    assign inst            = hit ? (inst_addr[2] ? buf_data[63:32] : buf_data[31:0]) : NOP_INST;
    // Gated by rst so the core sees no stall while the bridge is held in reset.
    assign stall           = ~rst & (miss | (state != IDLE));
    assign mem_req_addr    = {req_tag, 3'b000};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            buf_valid     <= 1'b0;
            buf_tag       <= '0;
            buf_data      <= '0;
            req_tag       <= '0;
            drop          <= 1'b0;
            mem_req_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (flush) buf_valid <= 1'b0;
                    if (miss) begin
                        req_tag       <= inst_addr[ADDR_W-1:3];
                        mem_req_valid <= 1'b1;
                        state         <= REQ;
                    end
                end
                REQ: begin
                    if (flush) drop <= 1'b1;
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        state         <= WAIT;
                    end
                end
                WAIT: begin
                    // A flush racing the fill still poisons it; drop is consumed here.
                    if (mem_resp_valid) begin
                        buf_data  <= mem_resp_data;
                        buf_tag   <= req_tag;
                        buf_valid <= ~drop & ~flush;
                        drop      <= 1'b0;
                        state     <= IDLE;
                    end else if (flush) begin
                        drop <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!rst) assert (!mem_resp_valid || state == WAIT)
            else $error("ifetch_bridge: memory response outside WAIT");
    end
`endif
endmodule

// File: tb/tb_ifetch_bridge.sv
// tb_ifetch_bridge: directed and randomized fetch traffic checked each cycle against
// a behavioural model of the line buffer and miss transaction.
module tb_ifetch_bridge;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] inst_addr = '0;
    logic        inst_ena = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] inst;
    logic        inst_valid;
    logic        stall;
    logic        inst_misaligned;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic [63:0] mem_req_addr;
    logic        mem_resp_valid = 1'b0;
    logic [63:0] mem_resp_data = '0;

    int checks = 0;
    int failures = 0;

    // model: phase 0 = no transaction, 1 = request offered, 2 = awaiting response
    int          m_phase;
    logic        m_bv;
    logic [60:0] m_btag;
    logic [63:0] m_bdata;
    logic [60:0] m_ptag;
    logic        m_drop;
    logic        m_miss;

    ifetch_bridge #(.ADDR_W(64), .NOP_INST(NOP)) dut (
        .clk(clk), .rst(rst), .inst_addr(inst_addr), .inst_ena(inst_ena), .flush(flush),
        .inst(inst), .inst_valid(inst_valid), .stall(stall), .inst_misaligned(inst_misaligned),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_bv = 0; m_btag = '0; m_bdata = '0; m_ptag = '0; m_drop = 0;
    endtask

    task automatic compare_model();
        logic mis, h;
        mis    = inst_ena && inst_addr[1:0] != 2'b00;
        h      = inst_ena && !mis && m_bv && m_btag == inst_addr[63:3] && m_phase == 0;
        m_miss = inst_ena && !mis && !h;
        chk("misaligned", 64'(inst_misaligned), 64'(mis));
        chk("inst_valid", 64'(inst_valid), 64'(h));
        chk("inst", 64'(inst), 64'(h ? (inst_addr[2] ? m_bdata[63:32] : m_bdata[31:0]) : NOP));
        chk("stall", 64'(stall), 64'(m_miss || m_phase != 0));
        chk("req_valid", 64'(mem_req_valid), 64'(m_phase == 1));
        if (m_phase == 1) chk("req_addr", mem_req_addr, {m_ptag, 3'b000});
    endtask

    task automatic drive(input logic e, input logic [63:0] a, input logic f, input logic r,
                         input logic rv, input logic [63:0] rd);
        inst_ena = e; inst_addr = a; flush = f; mem_req_ready = r;
        mem_resp_valid = rv; mem_resp_data = rd;
        #1 compare_model();
    endtask

    task automatic tick();
        @(posedge clk);
        case (m_phase)
            0: begin
                if (flush) m_bv = 0;
                if (m_miss) begin m_ptag = inst_addr[63:3]; m_phase = 1; end
            end
            1: begin
                if (flush) m_drop = 1;
                if (mem_req_ready) m_phase = 2;
            end
            default: begin
                if (mem_resp_valid) begin
                    m_bdata = mem_resp_data; m_btag = m_ptag;
                    m_bv = !m_drop && !flush; m_drop = 0; m_phase = 0;
                end else if (flush) m_drop = 1;
            end
        endcase
        @(negedge clk);
    endtask

    initial begin
        logic [63:0] a;
        model_reset();
        @(negedge clk);
        inst_ena = 1'b1; inst_addr = 64'h8000_0000;
        #1;
        chk("rst_stall", 64'(stall), 64'd0);
        chk("rst_inst_valid", 64'(inst_valid), 64'd0);
        chk("rst_req_valid", 64'(mem_req_valid), 64'd0);
        chk("rst_req_addr", mem_req_addr, 64'd0);
        chk("rst_inst", 64'(inst), 64'(NOP));
        @(negedge clk);
        rst = 1'b0;

        // minimum-penalty miss then both halves of the line
        drive(1, 64'h8000_0000, 0, 1, 0, 0);
        chk("miss_stall_c0", 64'(stall), 64'd1);
        tick();
        drive(1, 64'h8000_0000, 0, 1, 0, 0);
        chk("miss_req_c1", 64'(mem_req_valid), 64'd1);
        chk("miss_addr_c1", mem_req_addr, 64'h8000_0000);
        tick();
        drive(1, 64'h8000_0000, 0, 1, 1, 64'h0000_0093_0000_0013);
        chk("miss_stall_c2", 64'(stall), 64'd1);
        tick();
        drive(1, 64'h8000_0000, 0, 0, 0, 0);
        chk("hit_lo_inst", 64'(inst), 64'h13);
        chk("hit_lo_valid", 64'(inst_valid), 64'd1);
        chk("hit_lo_stall", 64'(stall), 64'd0);
        tick();
        drive(1, 64'h8000_0004, 0, 0, 0, 0);
        chk("hit_hi_inst", 64'(inst), 64'h93);
        chk("hit_hi_noreq", 64'(mem_req_valid), 64'd0);
        tick();

        // ready held low four cycles
        drive(1, 64'h8000_0008, 0, 0, 0, 0);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(1, 64'h8000_0008, 0, 0, 0, 0);
            chk("hold_req_valid", 64'(mem_req_valid), 64'd1);
            chk("hold_req_addr", mem_req_addr, 64'h8000_0008);
            chk("hold_stall", 64'(stall), 64'd1);
            tick();
        end
        drive(1, 64'h8000_0008, 0, 1, 0, 0);
        tick();
        drive(1, 64'h8000_0008, 0, 0, 1, 64'h1111_2222_3333_4444);
        tick();
        drive(1, 64'h8000_0008, 0, 0, 0, 0);
        chk("hold_fill_inst", 64'(inst), 64'h3333_4444);
        tick();

        // flush during WAIT poisons the fill
        drive(1, 64'h8000_0010, 0, 1, 0, 0);
        tick();
        drive(1, 64'h8000_0010, 0, 1, 0, 0);
        tick();
        drive(1, 64'h8000_0010, 1, 0, 0, 0);
        tick();
        drive(1, 64'h8000_0010, 0, 0, 1, 64'hAAAA_BBBB_CCCC_DDDD);
        tick();
        drive(1, 64'h8000_0010, 0, 0, 0, 0);
        chk("flush_refetch_valid", 64'(inst_valid), 64'd0);
        chk("flush_refetch_stall", 64'(stall), 64'd1);
        tick();
        drive(1, 64'h8000_0010, 0, 1, 0, 0);
        chk("flush_rereq", 64'(mem_req_valid), 64'd1);
        tick();
        drive(1, 64'h8000_0010, 0, 0, 1, 64'hAAAA_BBBB_CCCC_DDDD);
        tick();

        // misaligned fetch
        drive(1, 64'h8000_0002, 0, 1, 0, 0);
        chk("mis_flag", 64'(inst_misaligned), 64'd1);
        chk("mis_valid", 64'(inst_valid), 64'd0);
        chk("mis_stall", 64'(stall), 64'd0);
        chk("mis_inst", 64'(inst), 64'h13);
        tick();
        drive(1, 64'h8000_0002, 0, 1, 0, 0);
        chk("mis_noreq", 64'(mem_req_valid), 64'd0);
        tick();

        // async reset in WAIT; a late response during reset is ignored
        drive(1, 64'h8000_0018, 0, 1, 0, 0);
        tick();
        drive(1, 64'h8000_0018, 0, 1, 0, 0);
        tick();
        drive(1, 64'h8000_0018, 0, 0, 0, 0);
        #2 rst = 1'b1;
        #1;
        chk("arst_stall", 64'(stall), 64'd0);
        chk("arst_valid", 64'(inst_valid), 64'd0);
        chk("arst_req", 64'(mem_req_valid), 64'd0);
        model_reset();
        mem_resp_valid = 1'b1; mem_resp_data = 64'h5555_6666_7777_8888;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        drive(1, 64'h8000_0018, 0, 0, 0, 0);
        chk("arst_refetch", 64'(stall), 64'd1);
        chk("arst_nohit", 64'(inst_valid), 64'd0);
        tick();

        // randomized traffic
        for (int n = 0; n < 4000; n++) begin
            if (m_phase != 0 && $urandom_range(0, 9) != 0) a = inst_addr;
            else a = 64'h8000_0000 + 64'($urandom_range(0, 5)) * 8 + 64'($urandom_range(0, 1)) * 4
                   + (($urandom_range(0, 19) == 0) ? 64'd2 : 64'd0);
            drive($urandom_range(0, 9) != 0, a, $urandom_range(0, 19) == 0, 1'($urandom_range(0, 1)),
                  m_phase == 2 && $urandom_range(0, 2) == 0, {$urandom, $urandom});
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
